pattern_pin_timing: RTL and testbench
=====================================

Name: pattern_pin_timing

Overview:
- Per-tester-cycle pin timing generator for the vector-playback pattern engine.
- Each pulse on tester_sync starts one tester cycle. The block latches the 184-bit waveform-character vector (23 pins × 8-bit char) and the 4-bit waveform-table index.
- At a programmable drive offset it applies drive/enable to the pins; at a programmable strobe offset it compares pin inputs against expected levels.
- It reports per-cycle mismatches and keeps a fail count. It sits between the vector sequencer and the DUT pad ring.

Parameters:
- NPINS, 23, number of pins. Index order: SPI_MOSI, SPI_MISO, SPI_CS, SPI_CLK, I2C_SCL, I2C_SDA, JTAG_TCK, JTAG_TMS, JTAG_TDI, JTAG_TDO, JTAG_TRSTN, SWDIO, SWCLK, clock, reset, scan_in0..3, scan_out0..3 = 0..22.
- OFFW, 8, width of drive/strobe offsets in clock ticks.
- NWFT, 16, number of waveform tables.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- tester_sync  in  1  cycle-start strobe from sequencer (level; rising edge starts a cycle)
- wft  in  4  waveform-table index, sampled at cycle start
- wfc  in  8*NPINS  pin chars; pin i = wfc[8*NPINS-1-8*i -: 8]
- vector_number  in  32  tag latched for fail reporting
- cfg_we  in  1  timing-table write strobe
- cfg_wft  in  4  table entry to write
- cfg_drive_off  in  OFFW  drive offset
- cfg_strobe_off  in  OFFW  strobe offset
- finalize  in  1  end-of-pattern pulse
- pin_in  in  NPINS  sampled pad levels
- pin_drv  out  NPINS  drive value
- pin_oe  out  NPINS  output enable
- fail_valid  out  1  one-clock pulse at strobe when any pin mismatched
- fail_mask  out  NPINS  mismatching pins (valid with fail_valid)
- fail_vector  out  32  vector_number of the failing cycle
- fail_count  out  32  saturating count of failing cycles
- overrun  out  1  sticky: new cycle started before pending strobe
- illegal_wfc  out  1  sticky: undefined char seen

Behaviour:
- Reset values: pin_drv=0, pin_oe=0, fail_valid=0, fail_mask=0, fail_vector=0, fail_count=0, overrun=0, illegal_wfc=0, state IDLE. All table entries reset to drive_off=0, strobe_off=2. cfg writes take effect at the next cycle start.
- Cycle start: on a clock edge where tester_sync=1 and the previous sample was 0, latch wft, wfc and vector_number, and load tick counter=0. The counter increments every clock and saturates at 2^OFFW-1.
- Drive: at the edge where counter==drive_off(wft), update every pin from its char:
  - '0'(0x30): oe=1, drv=0
  - '1'(0x31): oe=1, drv=1
  - 'L'(0x4C), 'H'(0x48), 'X'(0x58), 'Z'(0x5A): oe=0, drv=0
  - 'N'(0x4E): hold the previous oe/drv
  - any other char: treated as 'X', and illegal_wfc is set.
- If drive_off=0, drive uses the incoming wfc on the start edge itself.
- Strobe: at the edge where counter==strobe_off(wft), compare each pin:
  - 'L' expects pin_in=0; 'H' expects pin_in=1.
  - All other chars are don't-care.
- If any pin mismatches: fail_valid=1 for one clock, fail_mask=mismatch bits, fail_vector=latched vector_number, and fail_count increments (saturating at 0xFFFFFFFF).
- Only one strobe is performed per cycle.
- States: IDLE → ACTIVE on cycle start. ACTIVE → DONE after both the drive and the strobe ticks have passed. DONE holds pin state until the next cycle start. Pins persist between cycles.
- Cycle start while the strobe is still pending: the pending strobe is dropped (no compare), overrun is set, and a new cycle starts.
- strobe_off < drive_off is legal; the compare then uses the pre-drive pin state.
- finalize: pin_oe=0 and pin_drv=0 next edge, any pending strobe is cancelled, state → IDLE. fail_count and sticky flags are kept. finalize together with a cycle start: finalize wins.
- reset during a cycle: everything returns to reset values.

Decomposition:
- Shared package pattern_pkg holds:
  - wfc char constants (WFC_0, WFC_1, WFC_L, WFC_H, WFC_X, WFC_Z, WFC_N)
  - the NPINS pin-index enum
  - timing entry struct {drive_off, strobe_off}
  - state enum
- One natural sub-module: pattern_pin_decode. It is combinational and maps one 8-bit char → {oe, drv, cmp_en, cmp_val, illegal}, instantiated NPINS times.

Test Plan:
- Reset, then sync with wft=0, all pins '1' → at tick 0 pin_oe=all ones, pin_drv=all ones; no fail.
- Table wft=3 {drive=4, strobe=6}; pin 9 'H', pin_in[9]=0 → pins change at tick 4; fail_valid at tick 6 with fail_mask=1<<9, fail_vector equal to the sync's vector_number, fail_count=1.
- pin 5 'N' after '0' cycle → pin 5 keeps oe=1, drv=0; pin 5 char 0x41 → treated as 'X', illegal_wfc=1.
- strobe=10; new sync at tick 5 → no fail_valid for the first cycle, overrun=1, second cycle strobes normally.
- 'L' on all pins with pin_in=0 over 3 cycles → fail_count stays 0; then pin_in[22]=1 → fail_count=1.
- finalize mid-cycle with strobe pending → pin_oe=0 next edge, no fail_valid, fail_count unchanged.

Source files
------------

// File: rtl/pattern_pkg.sv
// Shared types for the pattern-engine pin timing slice:
// waveform chars, pin indices, timing entries and cycle state.
package pattern_pkg;

  localparam int NPINS = 23;
  localparam int OFFW  = 8;
  localparam int NWFT  = 16;

  localparam logic [7:0] WFC_0 = 8'h30;
  localparam logic [7:0] WFC_1 = 8'h31;
  localparam logic [7:0] WFC_L = 8'h4C;
  localparam logic [7:0] WFC_H = 8'h48;
  localparam logic [7:0] WFC_X = 8'h58;
  localparam logic [7:0] WFC_Z = 8'h5A;
  localparam logic [7:0] WFC_N = 8'h4E;

  typedef enum logic [4:0] {
    PIN_SPI_MOSI,
    PIN_SPI_MISO,
    PIN_SPI_CS,
    PIN_SPI_CLK,
    PIN_I2C_SCL,
    PIN_I2C_SDA,
    PIN_JTAG_TCK,
    PIN_JTAG_TMS,
    PIN_JTAG_TDI,
    PIN_JTAG_TDO,
    PIN_JTAG_TRSTN,
    PIN_SWDIO,
    PIN_SWCLK,
    PIN_CLOCK,
    PIN_RESET,
    PIN_SCAN_IN0,
    PIN_SCAN_IN1,
    PIN_SCAN_IN2,
    PIN_SCAN_IN3,
    PIN_SCAN_OUT0,
    PIN_SCAN_OUT1,
    PIN_SCAN_OUT2,
    PIN_SCAN_OUT3
  } pin_e;

  typedef struct packed {
    logic [OFFW-1:0] drive_off;
    logic [OFFW-1:0] strobe_off;
  } timing_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_e;

  localparam logic [OFFW-1:0] OFF_MAX = '1;

  localparam timing_t TIMING_RST = '{
    drive_off:  '0,
    strobe_off: OFFW'(2)
  };

endpackage

// File: rtl/pattern_pin_decode.sv
// Maps one waveform char to drive, compare and
// hold controls for a single pin.
module pattern_pin_decode
  import pattern_pkg::*;
(
  input  logic [7:0] wfc,
  output logic       oe,
  output logic       drv,
  output logic       hold,
  output logic       cmp_en,
  output logic       cmp_val,
  output logic       illegal
);

  always_comb begin
    oe      = 1'b0;
    drv     = 1'b0;
    hold    = 1'b0;
    cmp_en  = 1'b0;
    cmp_val = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      (wfc == WFC_0): oe = 1'b1;
      (wfc == WFC_1): begin
        oe  = 1'b1;
        drv = 1'b1;
      end
      (wfc == WFC_L): cmp_en = 1'b1;
      (wfc == WFC_H): begin
        cmp_en  = 1'b1;
        cmp_val = 1'b1;
      end
      (wfc == WFC_X),
      (wfc == WFC_Z): ;
      (wfc == WFC_N): hold = 1'b1;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pattern_pin_timing.sv
// Per-tester-cycle pin timing: drives pins at the drive
// offset and compares pad levels at the strobe offset.
module pattern_pin_timing
  import pattern_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                tester_sync,
  input  logic [3:0]          wft,
  input  logic [8*NPINS-1:0]  wfc,
  input  logic [31:0]         vector_number,
  input  logic                cfg_we,
  input  logic [3:0]          cfg_wft,
  input  logic [OFFW-1:0]     cfg_drive_off,
  input  logic [OFFW-1:0]     cfg_strobe_off,
  input  logic                finalize,
  input  logic [NPINS-1:0]    pin_in,
  output logic [NPINS-1:0]    pin_drv,
  output logic [NPINS-1:0]    pin_oe,
  output logic                fail_valid,
  output logic [NPINS-1:0]    fail_mask,
  output logic [31:0]         fail_vector,
  output logic [31:0]         fail_count,
  output logic                overrun,
  output logic                illegal_wfc
);

  timing_t            tbl_q [NWFT];
  timing_t            cur_q;
  timing_t            eff_t;
  state_e             state_q;
  state_e             state_d;
  logic               sync_q;
  logic               start;
  logic               go;
  logic               live;
  logic               drv_hit;
  logic               stb_hit;
  logic [OFFW-1:0]    tick_q;
  logic [OFFW-1:0]    tick;
  logic               drv_done_q;
  logic               stb_done_q;
  logic               drv_done_d;
  logic               stb_done_d;
  logic [8*NPINS-1:0] wfc_q;
  logic [8*NPINS-1:0] eff_wfc;
  logic [31:0]        vec_q;
  logic [31:0]        eff_vec;
  logic [NPINS-1:0]   d_oe;
  logic [NPINS-1:0]   d_drv;
  logic [NPINS-1:0]   d_hold;
  logic [NPINS-1:0]   d_cen;
  logic [NPINS-1:0]   d_cval;
  logic [NPINS-1:0]   d_ill;
  logic [NPINS-1:0]   oe_d;
  logic [NPINS-1:0]   drv_d;
  logic [NPINS-1:0]   mism;

  for (genvar i = 0; i < NPINS; i++) begin : g_dec
    pattern_pin_decode u_dec (
      .wfc     (eff_wfc[8*NPINS-1-8*i -: 8]),
      .oe      (d_oe[i]),
      .drv     (d_drv[i]),
      .hold    (d_hold[i]),
      .cmp_en  (d_cen[i]),
      .cmp_val (d_cval[i]),
      .illegal (d_ill[i])
    );
  end

  // On the start edge the incoming vector acts as tick 0.
  always_comb begin
    start   = tester_sync & ~sync_q;
    go      = start & ~finalize;
    eff_t   = go ? tbl_q[wft] : cur_q;
    eff_wfc = go ? wfc : wfc_q;
    eff_vec = go ? vector_number : vec_q;
    tick    = go ? '0 : tick_q;
    live    = go | ((state_q == ST_ACTIVE) & ~finalize);
    drv_hit = live & (go | ~drv_done_q)
            & (tick == eff_t.drive_off);
    stb_hit = live & (go | ~stb_done_q)
            & (tick == eff_t.strobe_off);
    drv_done_d = (drv_done_q & ~go) | drv_hit;
    stb_done_d = (stb_done_q & ~go) | stb_hit;
    oe_d  = (d_hold & pin_oe) | (~d_hold & d_oe);
    drv_d = (d_hold & pin_drv) | (~d_hold & d_drv);
    mism  = d_cen & (pin_in ^ d_cval);
    state_d = state_q;
    if (finalize)
      state_d = ST_IDLE;
    else if (live && drv_done_d && stb_done_d)
      state_d = ST_DONE;
    else if (go)
      state_d = ST_ACTIVE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q      <= 1'b0;
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      cur_q       <= TIMING_RST;
      wfc_q       <= '0;
      vec_q       <= '0;
      drv_done_q  <= 1'b0;
      stb_done_q  <= 1'b0;
      pin_drv     <= '0;
      pin_oe      <= '0;
      fail_valid  <= 1'b0;
      fail_mask   <= '0;
      fail_vector <= '0;
      fail_count  <= '0;
      overrun     <= 1'b0;
      illegal_wfc <= 1'b0;
      for (int k = 0; k < NWFT; k++)
        tbl_q[k] <= TIMING_RST;
    end else begin
      sync_q     <= tester_sync;
      state_q    <= state_d;
      drv_done_q <= drv_done_d;
      stb_done_q <= stb_done_d;
      fail_valid <= 1'b0;
      if (go) begin
        cur_q  <= eff_t;
        wfc_q  <= wfc;
        vec_q  <= vector_number;
        tick_q <= OFFW'(1);
      end else if (tick_q != OFF_MAX) begin
        tick_q <= tick_q + OFFW'(1);
      end
      if (cfg_we)
        tbl_q[cfg_wft] <= '{
          drive_off:  cfg_drive_off,
          strobe_off: cfg_strobe_off
        };
      if (go && state_q == ST_ACTIVE && !stb_done_q)
        overrun <= 1'b1;
      if (finalize) begin
        pin_oe  <= '0;
        pin_drv <= '0;
      end else if (drv_hit) begin
        pin_oe  <= oe_d;
        pin_drv <= drv_d;
        if (|d_ill)
          illegal_wfc <= 1'b1;
      end
      if (stb_hit && |mism) begin
        fail_valid  <= 1'b1;
        fail_mask   <= mism;
        fail_vector <= eff_vec;
        if (fail_count != '1)
          fail_count <= fail_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pattern_pin_timing.sv
// Bench for pattern_pin_timing: directed plan checks plus
// randomized traffic against a cycle-level reference model.
module tb_pattern_pin_timing;
  import pattern_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               tester_sync;
  logic [3:0]         wft;
  logic [8*NPINS-1:0] wfc;
  logic [31:0]        vector_number;
  logic               cfg_we;
  logic [3:0]         cfg_wft;
  logic [OFFW-1:0]    cfg_drive_off;
  logic [OFFW-1:0]    cfg_strobe_off;
  logic               finalize;
  logic [NPINS-1:0]   pin_in;
  logic [NPINS-1:0]   pin_drv;
  logic [NPINS-1:0]   pin_oe;
  logic               fail_valid;
  logic [NPINS-1:0]   fail_mask;
  logic [31:0]        fail_vector;
  logic [31:0]        fail_count;
  logic               overrun;
  logic               illegal_wfc;

  always #5 clock = ~clock;

  pattern_pin_timing dut (
    .clock          (clock),
    .reset          (reset),
    .tester_sync    (tester_sync),
    .wft            (wft),
    .wfc            (wfc),
    .vector_number  (vector_number),
    .cfg_we         (cfg_we),
    .cfg_wft        (cfg_wft),
    .cfg_drive_off  (cfg_drive_off),
    .cfg_strobe_off (cfg_strobe_off),
    .finalize       (finalize),
    .pin_in         (pin_in),
    .pin_drv        (pin_drv),
    .pin_oe         (pin_oe),
    .fail_valid     (fail_valid),
    .fail_mask      (fail_mask),
    .fail_vector    (fail_vector),
    .fail_count     (fail_count),
    .overrun        (overrun),
    .illegal_wfc    (illegal_wfc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8*NPINS-1:0] put(
    input logic [8*NPINS-1:0] v, input int i, input logic [7:0] c);
    v[8*NPINS-1-8*i -: 8] = c;
    return v;
  endfunction

  function automatic logic [7:0] rnd_char();
    case ($urandom_range(0, 7))
      0: return 8'h30;
      1: return 8'h31;
      2: return 8'h4C;
      3: return 8'h48;
      4: return 8'h58;
      5: return 8'h5A;
      6: return 8'h4E;
      default: return 8'($urandom);
    endcase
  endfunction

  // Reference model: one record per tester cycle, tick =
  // clocks since its start, each action fires once.
  logic [7:0]       m_tbl_d [16];
  logic [7:0]       m_tbl_s [16];
  logic [7:0]       m_chars [NPINS];
  logic [NPINS-1:0] m_oe, m_drv, m_mask;
  logic [31:0]      m_vec, m_vec_out, m_count;
  logic [7:0]       m_doff, m_soff;
  logic             m_fv, m_ovr, m_ill, m_act, m_sync;
  logic             m_driven, m_strobed;
  int               m_n;

  always @(posedge clock) begin
    int t;
    logic [NPINS-1:0] mm;
    if (reset) begin
      for (int k = 0; k < 16; k++) begin
        m_tbl_d[k] = 8'd0;
        m_tbl_s[k] = 8'd2;
      end
      m_oe = '0; m_drv = '0; m_mask = '0;
      m_vec_out = 0; m_count = 0;
      m_fv = 0; m_ovr = 0; m_ill = 0;
      m_act = 0; m_sync = 0;
      m_driven = 0; m_strobed = 0; m_n = 0;
    end else begin
      m_fv = 0;
      if (finalize) begin
        m_oe = '0;
        m_drv = '0;
        m_act = 0;
      end else begin
        if (tester_sync && !m_sync) begin
          if (m_act && !m_strobed) m_ovr = 1;
          m_act = 1;
          m_n = 0;
          m_doff = m_tbl_d[wft];
          m_soff = m_tbl_s[wft];
          for (int i = 0; i < NPINS; i++)
            m_chars[i] = wfc[8*NPINS-1-8*i -: 8];
          m_vec = vector_number;
          m_driven = 0;
          m_strobed = 0;
        end
        if (m_act) begin
          t = (m_n > 255) ? 255 : m_n;
          if (!m_strobed && t == int'(m_soff)) begin
            mm = '0;
            for (int i = 0; i < NPINS; i++) begin
              if (m_chars[i] == 8'h4C && pin_in[i]) mm[i] = 1'b1;
              if (m_chars[i] == 8'h48 && !pin_in[i]) mm[i] = 1'b1;
            end
            if (mm != 0) begin
              m_fv = 1;
              m_mask = mm;
              m_vec_out = m_vec;
              if (m_count != 32'hFFFF_FFFF) m_count++;
            end
            m_strobed = 1;
          end
          if (!m_driven && t == int'(m_doff)) begin
            for (int i = 0; i < NPINS; i++) begin
              case (m_chars[i])
                8'h30: begin m_oe[i] = 1; m_drv[i] = 0; end
                8'h31: begin m_oe[i] = 1; m_drv[i] = 1; end
                8'h4C, 8'h48, 8'h58, 8'h5A:
                  begin m_oe[i] = 0; m_drv[i] = 0; end
                8'h4E: ;
                default: begin
                  m_oe[i] = 0; m_drv[i] = 0; m_ill = 1;
                end
              endcase
            end
            m_driven = 1;
          end
          if (m_driven && m_strobed) m_act = 0;
          m_n++;
        end
      end
      if (cfg_we) begin
        m_tbl_d[cfg_wft] = cfg_drive_off;
        m_tbl_s[cfg_wft] = cfg_strobe_off;
      end
      m_sync = tester_sync;
    end
  end

  always @(negedge clock) begin
    check("pin_oe", pin_oe, m_oe);
    check("pin_drv", pin_drv, m_drv);
    check("fail_valid", fail_valid, m_fv);
    if (m_fv) begin
      check("fail_mask", fail_mask, m_mask);
      check("fail_vector", fail_vector, m_vec_out);
    end
    check("fail_count", fail_count, m_count);
    check("overrun", overrun, m_ovr);
    check("illegal_wfc", illegal_wfc, m_ill);
  end

  task automatic sync_start(input logic [3:0] w,
                            input logic [8*NPINS-1:0] c,
                            input logic [31:0] v);
    wft = w;
    wfc = c;
    vector_number = v;
    tester_sync = 1;
    @(negedge clock);
    tester_sync = 0;
  endtask

  task automatic cfg(input logic [3:0] w,
                     input logic [7:0] d, input logic [7:0] s);
    cfg_we = 1;
    cfg_wft = w;
    cfg_drive_off = d;
    cfg_strobe_off = s;
    @(negedge clock);
    cfg_we = 0;
  endtask

  initial begin
    reset = 1; tester_sync = 0; wft = 0; wfc = '0;
    vector_number = 0; cfg_we = 0; cfg_wft = 0;
    cfg_drive_off = 0; cfg_strobe_off = 0;
    finalize = 0; pin_in = '0;
    repeat (3) @(negedge clock);
    check("rst_oe", pin_oe, 0);
    check("rst_count", fail_count, 0);
    check("rst_fv", fail_valid, 0);
    reset = 0;

    sync_start(4'd0, {NPINS{8'h31}}, 32'h100);
    check("t1_oe", pin_oe, 23'h7FFFFF);
    check("t1_drv", pin_drv, 23'h7FFFFF);
    repeat (4) @(negedge clock);
    check("t1_count", fail_count, 0);

    cfg(4'd3, 8'd4, 8'd6);
    pin_in = '0;
    sync_start(4'd3, put({NPINS{8'h30}}, 9, 8'h48), 32'hCAFE0009);
    check("t2_tick0_oe", pin_oe, 23'h7FFFFF);
    repeat (3) @(negedge clock);
    check("t2_tick3_oe", pin_oe, 23'h7FFFFF);
    @(negedge clock);
    check("t2_tick4_oe", pin_oe, 23'h7FFDFF);
    check("t2_tick4_drv", pin_drv, 0);
    @(negedge clock);
    check("t2_tick5_fv", fail_valid, 0);
    @(negedge clock);
    check("t2_fv", fail_valid, 1);
    check("t2_mask", fail_mask, 23'h000200);
    check("t2_vec", fail_vector, 32'hCAFE0009);
    check("t2_count", fail_count, 1);
    repeat (2) @(negedge clock);

    sync_start(4'd0, {NPINS{8'h30}}, 32'h200);
    repeat (3) @(negedge clock);
    sync_start(4'd0, put({NPINS{8'h58}}, 5, 8'h4E), 32'h201);
    check("t3_hold_oe", pin_oe, 23'h000020);
    check("t3_hold_drv", pin_drv, 0);
    check("t3_ill0", illegal_wfc, 0);
    repeat (3) @(negedge clock);
    sync_start(4'd0, put({NPINS{8'h4E}}, 5, 8'h41), 32'h202);
    check("t3_bad_oe", pin_oe, 0);
    check("t3_ill1", illegal_wfc, 1);
    repeat (3) @(negedge clock);

    cfg(4'd5, 8'd0, 8'd10);
    sync_start(4'd5, put({NPINS{8'h30}}, 9, 8'h48), 32'h44);
    repeat (4) @(negedge clock);
    check("t4_ovr0", overrun, 0);
    sync_start(4'd5, put({NPINS{8'h30}}, 9, 8'h48), 32'h45);
    check("t4_ovr1", overrun, 1);
    repeat (9) @(negedge clock);
    check("t4_fv_early", fail_valid, 0);
    @(negedge clock);
    check("t4_fv", fail_valid, 1);
    check("t4_vec", fail_vector, 32'h45);
    check("t4_count", fail_count, 2);
    repeat (2) @(negedge clock);

    for (int k = 0; k < 3; k++) begin
      sync_start(4'd0, {NPINS{8'h4C}}, 32'h300 + k);
      repeat (3) @(negedge clock);
    end
    check("t5_count_hold", fail_count, 2);
    pin_in = 23'h400000;
    sync_start(4'd0, {NPINS{8'h4C}}, 32'h303);
    repeat (2) @(negedge clock);
    check("t5_fv", fail_valid, 1);
    check("t5_mask", fail_mask, 23'h400000);
    check("t5_count", fail_count, 3);
    repeat (2) @(negedge clock);
    pin_in = '0;

    sync_start(4'd5, put({NPINS{8'h30}}, 9, 8'h48), 32'h400);
    repeat (3) @(negedge clock);
    finalize = 1;
    @(negedge clock);
    finalize = 0;
    check("t6_oe", pin_oe, 0);
    check("t6_drv", pin_drv, 0);
    repeat (12) @(negedge clock);
    check("t6_count", fail_count, 3);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) tester_sync = ~tester_sync;
      wft = 4'($urandom_range(0, 15));
      for (int i = 0; i < NPINS; i++)
        wfc[8*NPINS-1-8*i -: 8] = rnd_char();
      vector_number = $urandom;
      pin_in = 23'($urandom);
      cfg_we = ($urandom_range(0, 15) == 0);
      cfg_wft = 4'($urandom_range(0, 15));
      cfg_drive_off = 8'($urandom_range(0, 12));
      cfg_strobe_off = 8'($urandom_range(0, 12));
      finalize = ($urandom_range(0, 79) == 0);
    end
    reset = 0;
    finalize = 0;
    cfg_we = 0;
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
